// File: rtl/atm_session_ctrl_if.sv
// Datapath link between the session controller and the account datapath.
// The controller (master) raises a request with an op and amount; the
// datapath (slave) answers with a one-cycle ack, an error qualifier and
// the resulting balance.
interface atm_session_ctrl_if #(
    parameter int DW = 17
);
    logic          dp_req;
    logic [1:0]    dp_op;
    logic [DW-1:0] dp_amount;
    logic          dp_ack;
    logic          dp_err;
    logic [DW-1:0] balance_in;

    modport master (
        output dp_req,
        output dp_op,
        output dp_amount,
        input  dp_ack,
        input  dp_err,
        input  balance_in
    );

    modport slave (
        input  dp_req,
        input  dp_op,
        input  dp_amount,
        output dp_ack,
        output dp_err,
        output balance_in
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card presence, PIN check with retry limit and
// lockout, inactivity timeout, and dispatch of withdraw/deposit/balance
// commands to the account datapath. PIN change is handled locally.
module atm_session_ctrl #(
    parameter int          DW          = 17,
    parameter logic [16:0] PIN_DEFAULT = 17'd1211,
    parameter int          MAX_TRIES   = 3,
    parameter int          TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 card_i,
    input  logic                 pin_valid_i,
    input  logic [DW-1:0]        pin_i,
    input  logic                 cmd_valid_i,
    input  logic [1:0]           cmd_mode_i,
    input  logic [DW-1:0]        cmd_amount_i,
    input  logic [DW-1:0]        new_pin_i,
    atm_session_ctrl_if.master   dp,
    output logic [DW-1:0]        balance_o,
    output logic                 success_o,
    output logic                 error_o,
    output logic                 locked_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [1:0]    TRIES_LIMIT = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        PIN_WAIT,
        MENU,
        DP_WAIT,
        LOCKED
    } state_t;

    state_t        state_q;
    logic [1:0]    tries_q;
    logic [TW-1:0] timer_q;
    logic [DW-1:0] pin_reg_q;
    logic          dp_req_q;
    logic [1:0]    dp_op_q;
    logic [DW-1:0] dp_amount_q;
    logic [DW-1:0] balance_q;
    logic          success_q;
    logic          error_q;
    logic          locked_q;

    logic          timer_expired;
    logic          pin_match;
    logic          tries_exhausted;

    // Session-level conditions shared by the PIN_WAIT and MENU branches
    always_comb begin
        timer_expired   = (timer_q == TIMER_LAST);
        pin_match       = (pin_i == pin_reg_q);
        tries_exhausted = ((tries_q + 2'd1) == TRIES_LIMIT);
    end

    // Session FSM; every output is a register so the pulses are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tries_q     <= '0;
            timer_q     <= '0;
            pin_reg_q   <= DW'(PIN_DEFAULT);
            dp_req_q    <= 1'b0;
            dp_op_q     <= 2'b00;
            dp_amount_q <= '0;
            balance_q   <= '0;
            success_q   <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            success_q <= 1'b0;
            error_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (card_i) begin
                        state_q <= PIN_WAIT;
                        tries_q <= '0;
                        timer_q <= '0;
                    end
                end
                PIN_WAIT: begin
                    if (!card_i) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (timer_expired) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (pin_valid_i) begin
                        timer_q <= '0;
                        if (pin_match) begin
                            state_q <= MENU;
                            tries_q <= '0;
                        end else begin
                            error_q <= 1'b1;
                            tries_q <= tries_q + 2'd1;
                            if (tries_exhausted) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                MENU: begin
                    if (!card_i) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (timer_expired) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (cmd_valid_i) begin
                        timer_q <= '0;
                        case (cmd_mode_i)
                            2'b00, 2'b01: begin
                                if (cmd_amount_i == '0) begin
                                    error_q <= 1'b1;
                                end else begin
                                    state_q     <= DP_WAIT;
                                    dp_req_q    <= 1'b1;
                                    dp_op_q     <= cmd_mode_i;
                                    dp_amount_q <= cmd_amount_i;
                                end
                            end
                            2'b10: begin
                                state_q     <= DP_WAIT;
                                dp_req_q    <= 1'b1;
                                dp_op_q     <= 2'b10;
                                dp_amount_q <= '0;
                            end
                            default: begin
                                if (new_pin_i != '0) begin
                                    pin_reg_q <= new_pin_i;
                                    success_q <= 1'b1;
                                end else begin
                                    error_q <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DP_WAIT: begin
                    if (dp.dp_ack) begin
                        dp_req_q  <= 1'b0;
                        balance_q <= dp.balance_in;
                        success_q <= ~dp.dp_err;
                        error_q   <= dp.dp_err;
                        timer_q   <= '0;
                        state_q   <= card_i ? MENU : IDLE;
                    end
                end
                LOCKED: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dp.dp_req    = dp_req_q;
    assign dp.dp_op     = dp_op_q;
    assign dp.dp_amount = dp_amount_q;
    assign balance_o    = balance_q;
    assign success_o    = success_q;
    assign error_o      = error_q;
    assign locked_o     = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl. Stimulus pushes the expected
// datapath requests and result pulses into queues; a negedge monitor pops
// and compares whenever the DUT raises dp_req or pulses success/error.
module tb_atm_session_ctrl;

    localparam int DW = 17;

    typedef struct {
        logic          s;
        logic          e;
        logic          lk;
        logic [DW-1:0] bal;
    } resp_t;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] amt;
    } req_t;

    logic          clk;
    logic          rst;
    logic          card_i;
    logic          pin_valid_i;
    logic [DW-1:0] pin_i;
    logic          cmd_valid_i;
    logic [1:0]    cmd_mode_i;
    logic [DW-1:0] cmd_amount_i;
    logic [DW-1:0] new_pin_i;
    logic [DW-1:0] balance_o;
    logic          success_o;
    logic          error_o;
    logic          locked_o;

    int testsRun;
    int testsFailed;

    resp_t respQ[$];
    req_t  reqQ[$];

    logic          prevReq;
    logic [1:0]    heldOp;
    logic [DW-1:0] heldAmt;

    atm_session_ctrl_if #(.DW(DW)) dpIf ();

    atm_session_ctrl #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .card_i       (card_i),
        .pin_valid_i  (pin_valid_i),
        .pin_i        (pin_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_mode_i   (cmd_mode_i),
        .cmd_amount_i (cmd_amount_i),
        .new_pin_i    (new_pin_i),
        .dp           (dpIf),
        .balance_o    (balance_o),
        .success_o    (success_o),
        .error_o      (error_o),
        .locked_o     (locked_o)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Direct comparison of a DUT output against a bench-side constant
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectResp(input logic s, input logic e, input logic lk,
                              input logic [DW-1:0] bal);
        resp_t r;
        r.s = s; r.e = e; r.lk = lk; r.bal = bal;
        respQ.push_back(r);
    endtask

    task automatic expectReq(input logic [1:0] op, input logic [DW-1:0] amt);
        req_t r;
        r.op = op; r.amt = amt;
        reqQ.push_back(r);
    endtask

    // One-cycle PIN strobe
    task automatic applyStimulusPin(input logic [DW-1:0] p);
        pin_i       = p;
        pin_valid_i = 1'b1;
        tick(1);
        pin_valid_i = 1'b0;
    endtask

    // One-cycle command strobe
    task automatic applyStimulusCmd(input logic [1:0] mode, input logic [DW-1:0] amt,
                                    input logic [DW-1:0] np);
        cmd_mode_i   = mode;
        cmd_amount_i = amt;
        new_pin_i    = np;
        cmd_valid_i  = 1'b1;
        tick(1);
        cmd_valid_i  = 1'b0;
    endtask

    // One-cycle datapath acknowledge with error flag and balance
    task automatic applyStimulusAck(input logic err, input logic [DW-1:0] bal);
        dpIf.dp_ack     = 1'b1;
        dpIf.dp_err     = err;
        dpIf.balance_in = bal;
        tick(1);
        dpIf.dp_ack     = 1'b0;
        dpIf.dp_err     = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or a result pulse
    always @(negedge clk) begin
        if (dpIf.dp_req && !prevReq) begin
            testsRun++;
            if (reqQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_req: op=%0d amt=%0d with nothing expected",
                         dpIf.dp_op, dpIf.dp_amount);
            end else begin
                req_t r;
                r = reqQ.pop_front();
                if (dpIf.dp_op !== r.op || dpIf.dp_amount !== r.amt) begin
                    testsFailed++;
                    $display("[TB] FAIL req: op=%0d amt=%0d, expected op=%0d amt=%0d",
                             dpIf.dp_op, dpIf.dp_amount, r.op, r.amt);
                end
            end
            heldOp  = dpIf.dp_op;
            heldAmt = dpIf.dp_amount;
        end else if (dpIf.dp_req && prevReq) begin
            testsRun++;
            if (dpIf.dp_op !== heldOp || dpIf.dp_amount !== heldAmt) begin
                testsFailed++;
                $display("[TB] FAIL req_stable: op=%0d amt=%0d, expected op=%0d amt=%0d",
                         dpIf.dp_op, dpIf.dp_amount, heldOp, heldAmt);
            end
        end
        if (success_o || error_o) begin
            testsRun++;
            if (respQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_pulse: success=%0b error=%0b with nothing expected",
                         success_o, error_o);
            end else begin
                resp_t r;
                r = respQ.pop_front();
                if (success_o !== r.s || error_o !== r.e || locked_o !== r.lk ||
                    balance_o !== r.bal) begin
                    testsFailed++;
                    $display("[TB] FAIL resp: s=%0b e=%0b lk=%0b bal=%0d, expected s=%0b e=%0b lk=%0b bal=%0d",
                             success_o, error_o, locked_o, balance_o, r.s, r.e, r.lk, r.bal);
                end
            end
        end
        prevReq = dpIf.dp_req;
    end

    // Directed scenario sequence
    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        prevReq         = 1'b0;
        heldOp          = 2'b00;
        heldAmt         = '0;
        rst             = 1'b1;
        card_i          = 1'b0;
        pin_valid_i     = 1'b0;
        pin_i           = '0;
        cmd_valid_i     = 1'b0;
        cmd_mode_i      = 2'b00;
        cmd_amount_i    = '0;
        new_pin_i       = '0;
        dpIf.dp_ack     = 1'b0;
        dpIf.dp_err     = 1'b0;
        dpIf.balance_in = '0;
        tick(2);

        checkOutput("rst_dp_req",  32'(dpIf.dp_req), 0);
        checkOutput("rst_dp_op",   32'(dpIf.dp_op), 0);
        checkOutput("rst_balance", 32'(balance_o), 0);
        checkOutput("rst_locked",  32'(locked_o), 0);
        checkOutput("rst_pulses",  32'({success_o, error_o}), 0);
        rst = 1'b0;

        $display("[TB] withdraw 100 success");
        card_i = 1'b1;
        tick(1);
        applyStimulusPin(17'd1211);
        expectReq(2'b00, 17'd100);
        applyStimulusCmd(2'b00, 17'd100, 17'd0);
        tick(3);
        checkOutput("req_held", 32'(dpIf.dp_req), 1);
        expectResp(1'b1, 1'b0, 1'b0, 17'd900);
        applyStimulusAck(1'b0, 17'd900);
        checkOutput("req_dropped", 32'(dpIf.dp_req), 0);
        checkOutput("balance_900", 32'(balance_o), 900);

        $display("[TB] refused withdraw, zero amount, balance inquiry");
        expectReq(2'b00, 17'd500);
        applyStimulusCmd(2'b00, 17'd500, 17'd0);
        tick(1);
        expectResp(1'b0, 1'b1, 1'b0, 17'd900);
        applyStimulusAck(1'b1, 17'd900);
        expectResp(1'b0, 1'b1, 1'b0, 17'd900);
        applyStimulusCmd(2'b01, 17'd0, 17'd0);
        tick(1);
        checkOutput("zero_amt_no_req", 32'(dpIf.dp_req), 0);
        expectReq(2'b10, 17'd0);
        applyStimulusCmd(2'b10, 17'd77, 17'd0);
        expectResp(1'b1, 1'b0, 1'b0, 17'd900);
        applyStimulusAck(1'b0, 17'd900);

        $display("[TB] PIN change");
        expectResp(1'b1, 1'b0, 1'b0, 17'd900);
        applyStimulusCmd(2'b11, 17'd0, 17'd1234);
        expectResp(1'b0, 1'b1, 1'b0, 17'd900);
        applyStimulusCmd(2'b11, 17'd0, 17'd0);
        card_i = 1'b0;
        tick(1);
        card_i = 1'b1;
        tick(1);
        expectResp(1'b0, 1'b1, 1'b0, 17'd900);
        applyStimulusPin(17'd1211);
        applyStimulusPin(17'd1234);
        expectReq(2'b01, 17'd50);
        applyStimulusCmd(2'b01, 17'd50, 17'd0);
        expectResp(1'b1, 1'b0, 1'b0, 17'd950);
        applyStimulusAck(1'b0, 17'd950);

        $display("[TB] MENU inactivity timeout");
        tick(15);
        checkOutput("no_early_timeout", 32'(error_o), 0);
        expectResp(1'b0, 1'b1, 1'b0, 17'd950);
        tick(1);
        checkOutput("timeout_err", 32'(error_o), 1);

        $display("[TB] card removal during DP_WAIT");
        tick(1);
        applyStimulusPin(17'd1234);
        expectReq(2'b00, 17'd10);
        applyStimulusCmd(2'b00, 17'd10, 17'd0);
        card_i = 1'b0;
        tick(3);
        checkOutput("req_held_card_out", 32'(dpIf.dp_req), 1);
        expectResp(1'b1, 1'b0, 1'b0, 17'd940);
        applyStimulusAck(1'b0, 17'd940);
        checkOutput("req_done_card_out", 32'(dpIf.dp_req), 0);

        $display("[TB] reset mid-transaction");
        card_i = 1'b1;
        tick(1);
        applyStimulusPin(17'd1234);
        expectReq(2'b00, 17'd20);
        applyStimulusCmd(2'b00, 17'd20, 17'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("midrst_dp_req",  32'(dpIf.dp_req), 0);
        checkOutput("midrst_dp_amt",  32'(dpIf.dp_amount), 0);
        checkOutput("midrst_balance", 32'(balance_o), 0);
        tick(1);
        expectResp(1'b0, 1'b1, 1'b0, 17'd0);
        applyStimulusPin(17'd1234);
        applyStimulusPin(17'd1211);
        expectReq(2'b01, 17'd5);
        applyStimulusCmd(2'b01, 17'd5, 17'd0);
        expectResp(1'b1, 1'b0, 1'b0, 17'd5);
        applyStimulusAck(1'b0, 17'd5);

        $display("[TB] lockout");
        card_i = 1'b0;
        tick(1);
        card_i = 1'b1;
        tick(1);
        expectResp(1'b0, 1'b1, 1'b0, 17'd5);
        applyStimulusPin(17'd1000);
        expectResp(1'b0, 1'b1, 1'b0, 17'd5);
        applyStimulusPin(17'd1000);
        expectResp(1'b0, 1'b1, 1'b1, 17'd5);
        applyStimulusPin(17'd1000);
        card_i = 1'b0;
        tick(1);
        checkOutput("locked_card_out", 32'(locked_o), 1);
        card_i = 1'b1;
        tick(2);
        applyStimulusPin(17'd1211);
        applyStimulusCmd(2'b01, 17'd9, 17'd0);
        applyStimulusAck(1'b0, 17'd123);
        tick(1);
        checkOutput("locked_holds", 32'(locked_o), 1);
        checkOutput("locked_ack_ignored", 32'(balance_o), 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("unlock_by_rst", 32'(locked_o), 0);
        tick(2);

        checkOutput("resp_queue_empty", 32'(respQ.size()), 0);
        checkOutput("req_queue_empty",  32'(reqQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
